uart_tx_fifo_cfg: RTL and testbench

//  Parametrised UART transmitter. Frames are runtime-configurable: 5..DATA_BITS_MAX data bits,

---
 rtl/uart_tx_fifo_cfg.sv | 270 +++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo_cfg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_cfg.sv
// Purpose: UART transmitter with runtime frame config (5..DATA_BITS_MAX data, parity, 1/2 stop)
//          fed by a small valid/ready FIFO. Queued frames are sent back-to-back.
// Latency: push into an empty idle block -> start bit (tx=0) two edges later; bit = cfg_div+1 cycles.
// Backpressure: s_ready = !full; s_valid is ignored while full, even if a pop happens that cycle.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   cfg_div             bit period minus one, in clk cycles
//   cfg_data_bits       data bits per frame (clamped to 5..DATA_BITS_MAX)
//   cfg_parity          00/11 none, 01 odd, 10 even
//   cfg_stop2           1: two stop bits
//   s_valid/s_data      write port into the FIFO, LSB sent first
//   s_ready             FIFO not full
//   fifo_level          occupied FIFO entries
//   tx_active           high from the start-bit edge until the last stop bit ends
//   tx                  serial line, idle high

// Purpose: generic synchronous FIFO with pointer-decoded level.
// Latency: a push is visible at the head on the next cycle; head data is read combinationally.
// Backpressure: push_rdy_o = !full, so a pop in the same cycle does not free a slot for a push.
module uart_tx_fifo_cfg_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_vld_i,
    output logic                   push_rdy_o,
    input  logic [W-1:0]           push_dat_i,
    output logic                   pop_vld_o,
    input  logic                   pop_rdy_i,
    output logic [W-1:0]           pop_dat_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign push_rdy_o = (level_o != PTR_FULL);
    assign pop_vld_o  = (level_o != '0);
    assign do_push    = push_vld_i && push_rdy_o;
    assign do_pop     = pop_rdy_i && pop_vld_o;
    assign pop_dat_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
endmodule

module uart_tx_fifo_cfg #(
    parameter int DATA_BITS_MAX = 8,
    parameter int DIV_W         = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [3:0]                    cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic                          s_valid,
    input  logic [DATA_BITS_MAX-1:0]      s_data,
    output logic                          s_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_active,
    output logic                          tx
);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [3:0]       NB_MAX   = 4'(DATA_BITS_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                   state_q, state_d;
    logic [DIV_W-1:0]         div_cnt_q, div_cnt_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS_MAX-1:0] shift_q, shift_d;
    logic                     tx_q, tx_d;
    logic                     active_q, active_d;
    logic                     idle_avail_q;

    // Per-frame configuration, captured when the frame's word is popped.
    logic [DIV_W-1:0]         div_q;
    logic [3:0]               nbits_q;
    logic                     par_en_q;
    logic                     par_bit_q;
    logic                     stop2_q;

    logic                     fifo_vld;
    logic [DATA_BITS_MAX-1:0] fifo_dat;
    logic                     pop;
    logic                     bit_end;

    logic [3:0]               nbits_new;
    logic [DATA_BITS_MAX-1:0] mask_new;
    logic                     par_en_new;
    logic                     par_bit_new;

    uart_tx_fifo_cfg_fifo #(
        .W     (DATA_BITS_MAX),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_vld_i (s_valid),
        .push_rdy_o (s_ready),
        .push_dat_i (s_data),
        .pop_vld_o  (fifo_vld),
        .pop_rdy_i  (pop),
        .pop_dat_o  (fifo_dat),
        .level_o    (fifo_level)
    );

    // Frame parameters derived from the live cfg inputs; used only on the pop edge.
    always_comb begin
        nbits_new = cfg_data_bits;
        if (cfg_data_bits < 4'd5)   nbits_new = 4'd5;
        if (cfg_data_bits > NB_MAX) nbits_new = NB_MAX;
        mask_new = '0;
        for (int i = 0; i < DATA_BITS_MAX; i++) begin
            mask_new[i] = (i < int'(nbits_new));
        end
        par_en_new  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
        par_bit_new = (^(fifo_dat & mask_new)) ^ (cfg_parity == 2'b01);
    end

    assign bit_end = (div_cnt_q == div_q);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q + DIV_ONE;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        active_d  = active_q;
        pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                // idle_avail_q trails fifo_vld by one cycle; while idle the level can
                // only grow, so a set flag always means a word is present.
                if (idle_avail_q && fifo_vld) pop = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == nbits_q - 4'd1) begin
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d   = ST_STOP;
                            tx_d      = 1'b1;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_STOP;
                    tx_d      = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    // bit_cnt_q counts completed stop periods here.
                    if (stop2_q && (bit_cnt_q == 4'd0)) begin
                        bit_cnt_d = 4'd1;
                    end else if (fifo_vld) begin
                        pop = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        tx_d     = 1'b1;
                        active_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tx_d     = 1'b1;
                active_d = 1'b0;
            end
        endcase

        // Frame start, shared by the idle and back-to-back paths.
        if (pop) begin
            state_d   = ST_START;
            tx_d      = 1'b0;
            active_d  = 1'b1;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            shift_d   = fifo_dat & mask_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            active_q     <= 1'b0;
            idle_avail_q <= 1'b0;
            div_q        <= '0;
            nbits_q      <= 4'd5;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            stop2_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            active_q     <= active_d;
            idle_avail_q <= fifo_vld;
            if (pop) begin
                div_q     <= cfg_div;
                nbits_q   <= nbits_new;
                par_en_q  <= par_en_new;
                par_bit_q <= par_bit_new;
                stop2_q   <= cfg_stop2;
            end
        end
    end

    assign tx        = tx_q;
    assign tx_active = active_q;
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
module tb_uart_tx_fifo_cfg;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_div;
    logic [3:0]  cfg_data_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [2:0]  fifo_level;
    logic        tx_active;
    logic        tx;

    int n_asserts = 0;
    int n_fail    = 0;

    uart_tx_fifo_cfg #(
        .DATA_BITS_MAX (8),
        .DIV_W         (16),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_div       (cfg_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .fifo_level    (fifo_level),
        .tx_active     (tx_active),
        .tx            (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame model. par: 0 none, 1 odd, 2 even.
    function automatic int frame_len(input int nb, input int par, input int st2);
        return 1 + nb + ((par != 0) ? 1 : 0) + ((st2 != 0) ? 2 : 1);
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int nb, input int par,
                                       input int slot);
        logic p;
        p = 1'b0;
        for (int j = 0; j < nb; j++) p = p ^ d[j];
        if (par == 1) p = ~p;
        if (slot == 0)                  return 1'b0;
        if (slot <= nb)                 return d[slot-1];
        if ((par != 0) && slot == nb+1) return p;
        return 1'b1;
    endfunction

    // Starts at the sample just after the start-bit edge; ends just after the frame's last cycle.
    task automatic check_frame(input string tag, input logic [7:0] d, input int nb, input int par,
                               input int st2, input int cpb, input int chg_at,
                               input logic [15:0] chg_div);
        int len;
        len = frame_len(nb, par, st2);
        for (int i = 0; i < len * cpb; i++) begin
            if (i == chg_at) cfg_div = chg_div;
            check({tag, "_tx"}, tx, frame_bit(d, nb, par, i / cpb));
            check({tag, "_act"}, tx_active, 1);
            tick();
        end
    endtask

    // Single push into an empty idle block, returns at the start-bit sample.
    task automatic push_one(input string tag, input logic [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
        check({tag, "_lvl_k"}, fifo_level, 1);
        check({tag, "_tx_k"}, tx, 1);
        tick();
        check({tag, "_tx_k1"}, tx, 1);
        tick();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_act"}, tx_active, 0);
        check({tag, "_idle_tx"}, tx, 1);
        check({tag, "_idle_lvl"}, fifo_level, 0);
    endtask

    logic [7:0] d3 [5];

    initial begin
        d3[0] = 8'h01; d3[1] = 8'h80; d3[2] = 8'h3C; d3[3] = 8'hFF; d3[4] = 8'h00;
        rst = 1'b1;
        cfg_div = 16'd3; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        s_valid = 1'b0; s_data = 8'h00;
        tick();
        tick();
        check("rst_tx", tx, 1);
        check("rst_act", tx_active, 0);
        check("rst_rdy", s_ready, 1);
        check("rst_lvl", fifo_level, 0);
        rst = 1'b0;
        tick();

        // 1: 8N1, 4-cycle bits, 0xA5
        push_one("t1", 8'hA5);
        check("t1_lvl_start", fifo_level, 0);
        check_frame("t1", 8'hA5, 8, 0, 0, 4, -1, 16'd0);
        check_idle("t1");

        // 2: 7O2, 1-cycle bits; bit 7 set must be ignored
        cfg_div = 16'd0; cfg_data_bits = 4'd7; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
        tick();
        push_one("t2", 8'hC1);
        check_frame("t2", 8'hC1, 7, 1, 1, 1, -1, 16'd0);
        check_idle("t2");

        // clamp low: 3 -> 5 data bits, even parity
        cfg_data_bits = 4'd3; cfg_parity = 2'b10; cfg_stop2 = 1'b0;
        tick();
        push_one("clo", 8'h0F);
        check_frame("clo", 8'h0F, 5, 2, 0, 1, -1, 16'd0);
        check_idle("clo");

        // clamp high: 15 -> 8 data bits, parity code 11 = none
        cfg_data_bits = 4'd15; cfg_parity = 2'b11;
        tick();
        push_one("chi", 8'hA5);
        check_frame("chi", 8'hA5, 8, 0, 0, 1, -1, 16'd0);
        check_idle("chi");

        // 3 + 4: five consecutive pushes, full FIFO, pop with s_valid held high
        cfg_div = 16'd1; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        tick();
        s_valid = 1'b1;
        s_data = d3[0]; tick();
        check("t3_lvl_k", fifo_level, 1);
        s_data = d3[1]; tick();
        check("t3_lvl_k1", fifo_level, 2);
        s_data = d3[2]; tick();
        check("t3_tx_s", tx, 0);
        check("t3_lvl_s", fifo_level, 2);
        s_data = d3[3]; tick();
        check("t3_lvl_s1", fifo_level, 3);
        check("t3_rdy_s1", s_ready, 1);
        check("t3_tx_s1", tx, 0);
        s_data = d3[4]; tick();
        check("t3_lvl_s2", fifo_level, 4);
        check("t3_rdy_s2", s_ready, 0);
        s_data = 8'h77;
        for (int i = 2; i < 100; i++) begin
            check("t3_tx", tx, frame_bit(d3[i / 20], 8, 0, (i % 20) / 2));
            check("t3_act", tx_active, 1);
            if (i == 19) begin
                check("t4_lvl_full", fifo_level, 4);
                check("t4_rdy_full", s_ready, 0);
            end
            if (i == 20) begin
                check("t4_lvl_pop", fifo_level, 3);
                check("t4_rdy_pop", s_ready, 1);
                s_valid = 1'b0;
            end
            tick();
        end
        check_idle("t3");

        // 5: cfg_div 3 -> 7 in the middle of the first of two frames
        cfg_div = 16'd3;
        tick();
        s_valid = 1'b1;
        s_data = 8'h55; tick();
        s_data = 8'h0F; tick();
        s_valid = 1'b0;
        tick();
        check_frame("t5a", 8'h55, 8, 0, 0, 4, 14, 16'd7);
        check_frame("t5b", 8'h0F, 8, 0, 0, 8, -1, 16'd0);
        check_idle("t5");

        // 6: reset during DATA with two words queued
        cfg_div = 16'd3;
        tick();
        s_valid = 1'b1;
        s_data = 8'h33; tick();
        s_data = 8'h44; tick();
        s_data = 8'h55; tick();
        s_valid = 1'b0;
        check("t6_tx_s", tx, 0);
        check("t6_lvl_s", fifo_level, 2);
        for (int i = 0; i < 10; i++) tick();
        check("t6_tx_data", tx, 1);
        check("t6_act_data", tx_active, 1);
        rst = 1'b1;
        tick();
        check("t6_rst_tx", tx, 1);
        check("t6_rst_act", tx_active, 0);
        check("t6_rst_lvl", fifo_level, 0);
        check("t6_rst_rdy", s_ready, 1);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            check("t6_quiet_tx", tx, 1);
            check("t6_quiet_act", tx_active, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
